// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encodings, alu_op bit indices and IR field positions for control_sequencer
package ctrl_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    typedef enum logic [3:0] {S_RST, T0, T1, T2, T3, T4, T5, T6, S_HALT} state_t;
    localparam int A_AND  = 12;
    localparam int A_OR   = 11;
    localparam int A_ADD  = 10;
    localparam int A_SUB  = 9;
    localparam int A_MUL  = 8;
    localparam int A_DIV  = 7;
    localparam int A_SHR  = 6;
    localparam int A_SHRA = 5;
    localparam int A_SHL  = 4;
    localparam int A_ROR  = 3;
    localparam int A_ROL  = 2;
    localparam int A_NEG  = 1;
    localparam int A_NOT  = 0;
    localparam int OP_MSB = 31;
    localparam int RA_MSB = 26;
    localparam int RB_MSB = 22;
    localparam int RC_MSB = 18;
    localparam int FLD_W  = 4;
    function automatic logic [12:0] alu_sel(input logic [4:0] op);
        logic [12:0] s;
        s = '0;
        case (op)
            OP_AND:  s[A_AND]  = 1'b1;
            OP_OR:   s[A_OR]   = 1'b1;
            OP_ADD:  s[A_ADD]  = 1'b1;
            OP_SUB:  s[A_SUB]  = 1'b1;
            OP_MUL:  s[A_MUL]  = 1'b1;
            OP_DIV:  s[A_DIV]  = 1'b1;
            OP_SHR:  s[A_SHR]  = 1'b1;
            OP_SHRA: s[A_SHRA] = 1'b1;
            OP_SHL:  s[A_SHL]  = 1'b1;
            OP_ROR:  s[A_ROR]  = 1'b1;
            OP_ROL:  s[A_ROL]  = 1'b1;
            OP_NEG:  s[A_NEG]  = 1'b1;
            OP_NOT:  s[A_NOT]  = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/reg_select.sv
// reg_select: picks Ra/Rb/Rc by Gra/Grb/Grc and decodes it to one-hot Rout/Rin enables
module reg_select #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    input  logic [3:0]       rc,
    input  logic             gra,
    input  logic             grb,
    input  logic             grc,
    input  logic             rout_en,
    input  logic             rin_en,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin
);
    logic [3:0]       sel;
    logic [NREGS-1:0] oh;
    assign sel  = gra ? ra : grb ? rb : rc;
    assign oh   = (gra | grb | grc) ? NREGS'(1) << sel : '0;
    assign Rout = rout_en ? oh : '0;
    assign Rin  = rin_en ? oh : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the datapath; SINGLE_STEP_EN adds a step input gating T0
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic             PCout,
    output logic             MDRout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             PCin,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             Yin,
    output logic             Zin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [12:0]      alu_op,
    output logic             halted,
    output logic             illegal_op
);
    state_t           state, state_n;
    logic [31:0]      ir_q;
    logic [OPW-1:0]   op_now, op_q;
    logic             a2, md, un, t0_go;
    logic             gra, grb, grc, rout_en, rin_en;
    assign op_now = ir[OP_MSB -: OPW];
    assign op_q   = ir_q[OP_MSB -: OPW];
    assign a2 = op_q inside {OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR};
    assign md = op_q inside {OP_MUL, OP_DIV};
    assign un = op_q inside {OP_NEG, OP_NOT};
`ifdef SINGLE_STEP_EN
    logic go;
    always_ff @(posedge clk) begin
        if (!reset) go <= 1'b0;
        else go <= (state == T0) && !go && step;
    end
    assign t0_go = go;
`else
    assign t0_go = 1'b1;
`endif
    // IR is captured as it is loaded so T3..T6 decode a stable copy
    always_ff @(posedge clk) begin
        if (!reset) state <= S_RST;
        else state <= state_n;
        if (state == T2) ir_q <= ir;
    end
    always_comb begin
        state_n = state;
        {PCout, MDRout, Zhighout, Zlowout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read} = '0;
        {halted, illegal_op} = '0;
        {gra, grb, grc, rout_en, rin_en} = '0;
        alu_op = '0;
        case (state)
            S_RST: state_n = T0;
            T0: if (t0_go) begin
                {PCout, MARin, IncPC, PCin} = '1;
                state_n = T1;
            end
            T1: begin
                {Read, MDRin} = '1;
                state_n = mem_ready ? T2 : T1;
            end
            T2: begin
                {MDRout, IRin} = '1;
                state_n = op_now == OP_NOP ? T0 : op_now == OP_HALT ? S_HALT : T3;
            end
            T3: begin
                {grb, rout_en} = {2{a2 | md | un}};
                Yin = a2 | md;
                Zin = un;
                alu_op = un ? alu_sel(op_q) : '0;
                illegal_op = !(a2 | md | un);
                state_n = (a2 | md | un) ? T4 : T0;
            end
            T4: begin
                {Zlowout, gra, rin_en} = {3{un}};
                {grc, rout_en, Zin} = {3{!un}};
                alu_op = un ? '0 : alu_sel(op_q);
                state_n = un ? T0 : T5;
            end
            T5: begin
                Zlowout = 1'b1;
                LOin = md;
                {gra, rin_en} = {2{!md}};
                state_n = md ? T6 : T0;
            end
            T6: begin
                {Zhighout, HIin} = '1;
                state_n = T0;
            end
            S_HALT: halted = 1'b1;
            default: state_n = S_RST;
        endcase
    end
    reg_select #(.NREGS(NREGS)) u_sel (
        .ra(ir_q[RA_MSB -: FLD_W]),
        .rb(ir_q[RB_MSB -: FLD_W]),
        .rc(ir_q[RC_MSB -: FLD_W]),
        .gra(gra),
        .grb(grb),
        .grc(grc),
        .rout_en(rout_en),
        .rin_en(rin_en),
        .Rout(Rout),
        .Rin(Rin)
    );
endmodule
